load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_wait_ctr.sv | 49 ++++
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the load/store unit:
//                FSM state encoding, exception codes and the default
//                bus-timeout depth.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    // Two-state access FSM: IDLE accepts ops, REQ waits for the memory.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } lsu_state_t;

    // Exception codes; 0 is never reported.
    localparam logic [1:0] EXC_OVF   = 2'd1;
    localparam logic [1:0] EXC_ALIGN = 2'd2;
    localparam logic [1:0] EXC_BUS   = 2'd3;

    // REQ cycles without an ack before a bus-error exception is raised.
    localparam int LSU_MAX_WAIT_DEFAULT = 16;

endpackage : lsu_pkg

`default_nettype wire

// File: rtl/lsu_wait_ctr.sv
// ============================================================================
//  Module      : lsu_wait_ctr
//  Description : Bus wait counter. Cleared on REQ entry, counts REQ cycles
//                without an ack; tc_o flags the last permitted cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_wait_ctr #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count equals the number of REQ cycles already spent; reaching
    // MAX_WAIT-1 means the current cycle is the MAX_WAIT-th one.
    assign tc_o = (cnt_q == CW'(MAX_WAIT - 1));

endmodule : lsu_wait_ctr

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding load/store unit. ALU results are written
//                back one cycle later; lw/sw stall the pipe while a bus
//                request is open. Overflow, misalignment and bus timeouts are
//                reported on a registered exception port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = LSU_MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    input  logic        ex_overflow,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_code,
    output logic [31:0] exc_addr
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_st_q, is_st_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_valid_q, exc_valid_d;
    logic [1:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_addr_q, exc_addr_d;
    logic        stall_w;
    logic        ctr_clr_w;
    logic        ctr_en_w;
    logic        ctr_tc_w;
    logic        is_mem_w;
    logic        is_st_w;

    // Load flag wins when both are set, so a store is store-only.
    assign is_mem_w = ex_is_load | ex_is_store;
    assign is_st_w  = ex_is_store & ~ex_is_load;

    lsu_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (ctr_clr_w),
        .en_i  (ctr_en_w),
        .tc_o  (ctr_tc_w)
    );

    // Next-state, write-back/exception staging and stall generation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        is_st_d     = is_st_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        exc_valid_d = 1'b0;
        exc_code_d  = exc_code_q;
        exc_addr_d  = exc_addr_q;
        stall_w     = 1'b0;
        ctr_clr_w   = 1'b0;
        ctr_en_w    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (ex_overflow) begin
                        exc_valid_d = 1'b1;
                        exc_code_d  = EXC_OVF;
                        exc_addr_d  = ex_addr;
                    end else if (is_mem_w && (ex_addr[1:0] != 2'b00)) begin
                        exc_valid_d = 1'b1;
                        exc_code_d  = EXC_ALIGN;
                        exc_addr_d  = ex_addr;
                    end else if (is_mem_w) begin
                        stall_w   = 1'b1;
                        state_d   = ST_REQ;
                        addr_d    = ex_addr;
                        wdata_d   = ex_wdata;
                        rd_d      = ex_rd;
                        is_st_d   = is_st_w;
                        ctr_clr_w = 1'b1;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = (ex_rd != 5'd0);
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_addr;
                    end
                end
            end
            ST_REQ: begin
                // An ack on the terminal cycle completes normally.
                if (dm_ack) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (!is_st_q) begin
                        wb_data_d = dm_rdata;
                        wb_we_d   = (rd_q != 5'd0);
                    end
                end else if (ctr_tc_w) begin
                    state_d     = ST_IDLE;
                    exc_valid_d = 1'b1;
                    exc_code_d  = EXC_BUS;
                    exc_addr_d  = addr_q;
                end else begin
                    stall_w  = 1'b1;
                    ctr_en_w = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered output ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            is_st_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_code_q  <= '0;
            exc_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            is_st_q     <= is_st_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_valid_q <= exc_valid_d;
            exc_code_q  <= exc_code_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    // Stall is masked while reset is held so upstream never freezes on it.
    assign stall     = stall_w & rst_n;
    assign dm_req    = (state_q == ST_REQ);
    assign dm_we     = (state_q == ST_REQ) & is_st_q;
    assign dm_addr   = addr_q;
    assign dm_wdata  = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_code  = exc_code_q;
    assign exc_addr  = exc_addr_q;

endmodule : load_store_unit

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit: a table of
//                single-cycle ops plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_is_load, ex_is_store, ex_overflow;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall, dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        wb_valid, wb_we, exc_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_addr;
    logic [1:0]  exc_code;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.MAX_WAIT(16)) dut (
        .clk (clk), .rst_n (rst_n),
        .ex_valid (ex_valid), .ex_is_load (ex_is_load), .ex_is_store (ex_is_store),
        .ex_addr (ex_addr), .ex_wdata (ex_wdata), .ex_rd (ex_rd),
        .ex_overflow (ex_overflow), .stall (stall),
        .dm_req (dm_req), .dm_we (dm_we), .dm_addr (dm_addr), .dm_wdata (dm_wdata),
        .dm_ack (dm_ack), .dm_rdata (dm_rdata),
        .wb_valid (wb_valid), .wb_we (wb_we), .wb_rd (wb_rd), .wb_data (wb_data),
        .exc_valid (exc_valid), .exc_code (exc_code), .exc_addr (exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, ld, st, ovf;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic        e_wb, e_we;
        logic [31:0] e_data;
        logic        e_exc;
        logic [1:0]  e_code;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic ovf,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_overflow = ovf;
        ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    endtask

    initial begin
        int n;
        int stall_cnt;
        logic held_ok;
        logic stall_ok;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0005, 5'd3,  1'b1, 1'b1, 32'h5,         1'b0, 2'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 5'd0,  1'b1, 1'b0, 32'h1234,      1'b0, 2'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 5'd2,  1'b0, 1'b0, 32'h102,       1'b1, 2'd1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0102, 5'd2,  1'b0, 1'b0, 32'h102,       1'b1, 2'd2};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0101, 5'd7,  1'b0, 1'b0, 32'h101,       1'b1, 2'd2};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 5'd9,  1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 2'd1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 5'd4,  1'b0, 1'b0, 32'h0,         1'b0, 2'd0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0003, 5'd1,  1'b0, 1'b0, 32'h3,         1'b1, 2'd2};

        // Reset with a valid aligned load presented: nothing may leak out.
        rst_n = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd8);
        tick(); tick();
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_ctrl", {26'b0, dm_req, dm_we, wb_valid, wb_we, exc_valid, 1'b0}, 32'd0);
        check("reset_data", dm_addr | dm_wdata | wb_data | exc_addr | {25'b0, wb_rd, exc_code}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rst_n = 1'b1;
        tick();

        // Single-cycle ops: results one cycle later, no stall, no bus access.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].v, vecs[i].ld, vecs[i].st, vecs[i].ovf, vecs[i].addr, 32'hA5A5_0000, vecs[i].rd);
            #1;
            check($sformatf("v%0d_stall", i), {31'b0, stall}, 32'd0);
            tick();
            check($sformatf("v%0d_dm_req", i), {31'b0, dm_req}, 32'd0);
            check($sformatf("v%0d_wb_valid", i), {31'b0, wb_valid}, {31'b0, vecs[i].e_wb});
            check($sformatf("v%0d_exc_valid", i), {31'b0, exc_valid}, {31'b0, vecs[i].e_exc});
            if (vecs[i].e_wb) begin
                check($sformatf("v%0d_wb_we", i), {31'b0, wb_we}, {31'b0, vecs[i].e_we});
                check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_data);
                check($sformatf("v%0d_wb_rd", i), {27'b0, wb_rd}, {27'b0, vecs[i].rd});
            end
            if (vecs[i].e_exc) begin
                check($sformatf("v%0d_exc_code", i), {30'b0, exc_code}, {30'b0, vecs[i].e_code});
                check($sformatf("v%0d_exc_addr", i), exc_addr, vecs[i].e_data);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        check("idle_quiet", {30'b0, wb_valid, exc_valid}, 32'd0);

        // Load with ack after 3 waiting REQ cycles.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd8);
        stall_cnt = 0;
        #1; if (stall) stall_cnt++;
        tick();
        check("ld_dm_req", {31'b0, dm_req}, 32'd1);
        check("ld_dm_we", {31'b0, dm_we}, 32'd0);
        check("ld_dm_addr", dm_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            if (stall) stall_cnt++;
            tick();
        end
        dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        #1; if (stall) stall_cnt++;
        check("ld_stall_cycles", stall_cnt, 32'd4);
        tick();
        dm_ack = 1'b0; ex_valid = 1'b0;
        check("ld_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("ld_wb_data", wb_data, 32'hDEAD_BEEF);
        check("ld_wb_rd", {27'b0, wb_rd}, 32'd8);
        check("ld_wb_we", {31'b0, wb_we}, 32'd1);
        check("ld_no_exc", {31'b0, exc_valid}, 32'd0);
        check("ld_req_done", {31'b0, dm_req}, 32'd0);

        // Minimum latency: ack in the first REQ cycle, write-back two cycles on.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 5'd5);
        tick();
        dm_ack = 1'b1; dm_rdata = 32'h0000_CAFE;
        #1;
        check("lat_stall_drop", {31'b0, stall}, 32'd0);
        tick();
        dm_ack = 1'b0; ex_valid = 1'b0;
        check("lat_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("lat_wb_data", wb_data, 32'h0000_CAFE);
        tick();
        check("lat_wb_pulse", {31'b0, wb_valid}, 32'd0);

        // Store with no ack: bus timeout after 16 REQ cycles.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h55AA_1234, 5'd6);
        tick();
        n = 0; held_ok = 1'b1; stall_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!dm_req) break;
            n++;
            if (dm_addr !== 32'h40 || dm_wdata !== 32'h55AA_1234 || dm_we !== 1'b1) held_ok = 1'b0;
            if (n < 16 && stall !== 1'b1) stall_ok = 1'b0;
            if (!stall) ex_valid = 1'b0;
            tick();
        end
        ex_valid = 1'b0;
        check("to_req_cycles", n, 32'd16);
        check("to_bus_held", {31'b0, held_ok}, 32'd1);
        check("to_stall_held", {31'b0, stall_ok}, 32'd1);
        check("to_exc_valid", {31'b0, exc_valid}, 32'd1);
        check("to_exc_code", {30'b0, exc_code}, 32'd3);
        check("to_exc_addr", exc_addr, 32'h40);
        check("to_no_wb", {31'b0, wb_valid}, 32'd0);
        check("to_stall_idle", {31'b0, stall}, 32'd0);
        tick();
        check("to_exc_pulse", {31'b0, exc_valid}, 32'd0);

        // Store acked in the 16th REQ cycle: completes normally.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0BAD_F00D, 5'd6);
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("ack16_still_req", {31'b0, dm_req}, 32'd1);
        dm_ack = 1'b1;
        #1;
        check("ack16_stall", {31'b0, stall}, 32'd0);
        tick();
        dm_ack = 1'b0; ex_valid = 1'b0;
        check("ack16_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("ack16_wb_we", {31'b0, wb_we}, 32'd0);
        check("ack16_no_exc", {31'b0, exc_valid}, 32'd0);
        tick();
        check("ack16_late_exc", {30'b0, exc_valid, dm_req}, 32'd0);

        // Load to r0: write-back pulse without a register write.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 5'd0);
        tick();
        dm_ack = 1'b1; dm_rdata = 32'h77;
        tick();
        dm_ack = 1'b0; ex_valid = 1'b0;
        check("r0_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("r0_wb_we", {31'b0, wb_we}, 32'd0);

        // Reset in the middle of a request, then a stray ack.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd4);
        tick(); tick();
        rst_n = 1'b0; ex_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_req_drop", {31'b0, dm_req}, 32'd0);
        check("rst_no_events", {30'b0, wb_valid, exc_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
        #1;
        check("stray_ack_stall", {31'b0, stall}, 32'd0);
        tick();
        dm_ack = 1'b0;
        check("stray_ack_ignored", {29'b0, wb_valid, exc_valid, dm_req}, 32'd0);
        tick();
        check("stray_ack_after", {30'b0, wb_valid, exc_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule : tb_load_store_unit

`default_nettype wire
